// File: rtl/arcade_input_cond.sv
// arcade_input_cond
//   Conditions raw OSD/joystick bits before they reach the galaga core:
//   per-bit debounce, coin press to fixed-length coin pulse (with a
//   mandatory low gap and a one-credit queue), and the pause / video-dim
//   generation.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | coin low, waiting for a debounced coin press
//   PULSE   | coin high for COIN_PULSE_CYC cycles
//   GAP     | coin low for COIN_GAP_CYC cycles, then next queued credit
//
// Ports
//   i_clk_sys       system clock, sole clock
//   i_reset         synchronous active-high reset
//   i_joy_in[15:0]  raw joystick bits (0 R,1 L,2 D,3 U,4 fire,5 start1,
//                   6 start2,7 coin,8 pause; 15:9 unused)
//   i_osd_open      OSD displayed
//   i_osd_pause_en  pause while OSD is open
//   i_hs_access     hiscore module owns RAM, forces pause
//   o_right..o_start2  debounced controls
//   o_coin          shaped coin pulse
//   o_pause         core pause request (registered)
//   o_dim_video     halve RGB output after a long user pause
module arcade_input_cond #(
    parameter int DEBOUNCE_CYC   = 18432,
    parameter int COIN_PULSE_CYC = 1843200,
    parameter int COIN_GAP_CYC   = 921600,
    parameter int DIM_CYC        = 180000000
) (
    input  logic        i_clk_sys,
    input  logic        i_reset,
    input  logic [15:0] i_joy_in,
    input  logic        i_osd_open,
    input  logic        i_osd_pause_en,
    input  logic        i_hs_access,
    output logic        o_right,
    output logic        o_left,
    output logic        o_down,
    output logic        o_up,
    output logic        o_fire,
    output logic        o_start1,
    output logic        o_start2,
    output logic        o_coin,
    output logic        o_pause,
    output logic        o_dim_video
);

    localparam int DB_W     = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int COIN_MAX = (COIN_PULSE_CYC > COIN_GAP_CYC) ? COIN_PULSE_CYC : COIN_GAP_CYC;
    localparam int CT_W     = (COIN_MAX > 1) ? $clog2(COIN_MAX) : 1;

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [CT_W-1:0] PULSE_LAST = CT_W'(COIN_PULSE_CYC - 1);
    localparam logic [CT_W-1:0] GAP_LAST   = CT_W'(COIN_GAP_CYC - 1);
    localparam logic [31:0]     DIM_LIMIT  = 32'(DIM_CYC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } coin_state_t;

    // ------------------------------------------------------------------
    // Debounce: bits 0..8 are filtered independently.
    // ------------------------------------------------------------------
    logic [8:0]      r_db;
    logic [DB_W-1:0] r_db_cnt [9];

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_db <= '0;
            for (int i = 0; i < 9; i++) r_db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 9; i++) begin
                if (i_joy_in[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db[i]     <= i_joy_in[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign o_right  = r_db[0];
    assign o_left   = r_db[1];
    assign o_down   = r_db[2];
    assign o_up     = r_db[3];
    assign o_fire   = r_db[4];
    assign o_start1 = r_db[5];
    assign o_start2 = r_db[6];

    logic w_unused_joy;
    assign w_unused_joy = ^i_joy_in[15:9];

    // ------------------------------------------------------------------
    // Edge detection on the debounced coin and pause bits
    // ------------------------------------------------------------------
    logic r_coin_prev;
    logic r_pause_prev;
    logic w_coin_rise;
    logic w_pause_rise;

    assign w_coin_rise  = r_db[7] & ~r_coin_prev;
    assign w_pause_rise = r_db[8] & ~r_pause_prev;

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_coin_prev  <= 1'b0;
            r_pause_prev <= 1'b0;
        end else begin
            r_coin_prev  <= r_db[7];
            r_pause_prev <= r_db[8];
        end
    end

    // ------------------------------------------------------------------
    // Coin FSM
    // ------------------------------------------------------------------
    coin_state_t     r_state;
    coin_state_t     w_state_nxt;
    logic [CT_W-1:0] r_timer;
    logic [CT_W-1:0] w_timer_nxt;
    logic            r_pending;
    logic            w_pending_nxt;

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_pending_nxt = r_pending;
        case (r_state)
            ST_IDLE: begin
                if (w_coin_rise) begin
                    w_state_nxt = ST_PULSE;
                    w_timer_nxt = '0;
                end
            end
            ST_PULSE: begin
                if (w_coin_rise) w_pending_nxt = 1'b1;
                if (r_timer == PULSE_LAST) begin
                    w_state_nxt = ST_GAP;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + CT_W'(1);
                end
            end
            ST_GAP: begin
                if (r_timer == GAP_LAST) begin
                    w_timer_nxt = '0;
                    // A queued credit wins; a rise landing on the expiry
                    // cycle with nothing queued starts the pulse directly.
                    // With a credit already queued, that rise is dropped.
                    if (r_pending) begin
                        w_state_nxt   = ST_PULSE;
                        w_pending_nxt = 1'b0;
                    end else if (w_coin_rise) begin
                        w_state_nxt = ST_PULSE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_timer_nxt = r_timer + CT_W'(1);
                    if (w_coin_rise) w_pending_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_timer_nxt   = '0;
                w_pending_nxt = 1'b0;
            end
        endcase
    end

    assign o_coin = (r_state == ST_PULSE);

    // ------------------------------------------------------------------
    // Pause toggle, pause request and dim timer
    // ------------------------------------------------------------------
    logic        r_toggle;
    logic        r_pause;
    logic        r_dim;
    logic [31:0] r_dim_cnt;

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_toggle  <= 1'b0;
            r_pause   <= 1'b0;
            r_dim     <= 1'b0;
            r_dim_cnt <= '0;
        end else begin
            if (w_pause_rise) r_toggle <= ~r_toggle;
            r_pause <= r_toggle | i_hs_access | (i_osd_open & i_osd_pause_en);
            if (!r_toggle) begin
                r_dim_cnt <= '0;
            end else if (r_dim_cnt < DIM_LIMIT) begin
                r_dim_cnt <= r_dim_cnt + 32'd1;
            end
            // Gated by the toggle so untoggling drops dim together with pause.
            r_dim <= r_toggle & (r_dim_cnt >= DIM_LIMIT);
        end
    end

    assign o_pause     = r_pause;
    assign o_dim_video = r_dim;

endmodule
